// File: rtl/alu_pkg.sv
// Shared opcode nibbles, PSR flag bit positions, FSM states and the opcode decoder for alu_pipe.
// Immediate forms reuse the register-form low nibble as their upper nibble, so both forms decode the same way.
package alu_pkg;

    localparam logic [3:0] NIB_AND   = 4'h1;
    localparam logic [3:0] NIB_OR    = 4'h2;
    localparam logic [3:0] NIB_XOR   = 4'h3;
    localparam logic [3:0] NIB_ADDCU = 4'h4;
    localparam logic [3:0] NIB_ADD   = 4'h5;
    localparam logic [3:0] NIB_ADDU  = 4'h6;
    localparam logic [3:0] NIB_ADDC  = 4'h7;
    localparam logic [3:0] NIB_SUB   = 4'h9;
    localparam logic [3:0] NIB_CMP   = 4'hB;
    localparam logic [3:0] NIB_MOV   = 4'hD;

    localparam logic [7:0] OPC_LSH = 8'h84;
    localparam logic [7:0] OPC_MUL = 8'h0E;

    localparam int FLAG_Z = 4;
    localparam int FLAG_C = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_L = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        ALU_ILL, ALU_AND, ALU_OR, ALU_XOR, ALU_ADD, ALU_ADDU, ALU_ADDC,
        ALU_ADDCU, ALU_SUB, ALU_CMP, ALU_MOV, ALU_LSH, ALU_MUL
    } alu_op_t;

    function automatic alu_op_t decode(input logic [7:0] opc, input logic mul_en);
        logic [3:0] nib;
        alu_op_t    dec;
        nib = (opc[7:4] == 4'h0) ? opc[3:0] : opc[7:4];
        case (nib)
            NIB_AND:   dec = ALU_AND;
            NIB_OR:    dec = ALU_OR;
            NIB_XOR:   dec = ALU_XOR;
            NIB_ADDCU: dec = ALU_ADDCU;
            NIB_ADD:   dec = ALU_ADD;
            NIB_ADDU:  dec = ALU_ADDU;
            NIB_ADDC:  dec = ALU_ADDC;
            NIB_SUB:   dec = ALU_SUB;
            NIB_CMP:   dec = ALU_CMP;
            NIB_MOV:   dec = ALU_MOV;
            default:   dec = ALU_ILL;
        endcase
        // LSH and MUL have no immediate form; only their exact codes decode.
        if (opc == OPC_LSH) dec = ALU_LSH;
        if (opc == OPC_MUL && mul_en) dec = ALU_MUL;
        return dec;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential signed multiplier: magnitude shift-add over WIDTH cycles, sign applied on the way out.
// done is high in the WIDTH-th cycle after start with the full product on the same cycle; no backpressure.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   mplier;
    logic               neg;
    logic               busy;
    logic [6:0]         count;

    // The final partial product is folded in combinationally so done lines up with the last step.
    assign acc_step = acc + (mplier[0] ? mcand : '0);
    assign done     = busy && (count == 7'(WIDTH-1));
    assign product  = neg ? -acc_step : acc_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= 1'b0;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
        end else if (start) begin
            busy   <= 1'b1;
            count  <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, (a[WIDTH-1] ? -a : a)};
            mplier <= b[WIDTH-1] ? -b : b;
            neg    <= a[WIDTH-1] ^ b[WIDTH-1];
        end else if (busy) begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 7'd1;
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU with PSR flags: single-cycle ops return 1 cycle after transfer, MUL WIDTH+1 cycles after.
// in_ready drops only while MUL is stepping; results always leave in acceptance order.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [7:0]       Opcode,
    output logic             out_valid,
    output logic [WIDTH-1:0] C,
    output logic [4:0]       Flags,
    output logic             illegal
);

    state_t             state;
    alu_op_t            op;
    logic [4:0]         psr;
    logic [4:0]         psr_nxt;
    logic               fire;
    logic               mul_start;
    logic               mul_done;
    logic               mul_ovf;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0]   res;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic               cin;
    logic               shr;
    logic [WIDTH-1:0]   shamt;

    assign op        = decode(Opcode, MUL_EN);
    assign in_ready  = (state != ST_MUL);
    assign fire      = in_valid && in_ready;
    assign mul_start = fire && (op == ALU_MUL);
    assign Flags     = psr;
    assign mul_ovf   = !(&mul_prod[2*WIDTH-1:WIDTH-1]) && (|mul_prod[2*WIDTH-1:WIDTH-1]);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (A),
        .b       (B),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_comb begin
        cin     = (op == ALU_ADDC || op == ALU_ADDCU) ? psr[FLAG_C] : 1'b0;
        sum     = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, cin};
        diff    = {1'b0, A} - {1'b0, B};
        shr     = B[WIDTH-1];
        shamt   = shr ? -B : B;
        res     = '0;
        psr_nxt = psr;
        case (op)
            ALU_ADD, ALU_ADDC: begin
                res             = sum[WIDTH-1:0];
                psr_nxt[FLAG_C] = sum[WIDTH];
                psr_nxt[FLAG_F] = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            ALU_ADDU, ALU_ADDCU: begin
                res             = sum[WIDTH-1:0];
                psr_nxt[FLAG_C] = sum[WIDTH];
            end
            ALU_SUB: begin
                res             = diff[WIDTH-1:0];
                psr_nxt[FLAG_C] = diff[WIDTH];
                psr_nxt[FLAG_F] = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            ALU_CMP: begin
                res             = A;
                psr_nxt[FLAG_L] = diff[WIDTH];
                psr_nxt[FLAG_N] = $signed(A) < $signed(B);
            end
            ALU_AND: res = A & B;
            ALU_OR:  res = A | B;
            ALU_XOR: res = A ^ B;
            ALU_MOV: res = B;
            ALU_LSH: begin
                if (shamt >= WIDTH'(WIDTH)) res = '0;
                else if (shr)               res = A >> shamt;
                else                        res = A << shamt;
            end
            default: res = '0;
        endcase
        if (op == ALU_CMP)
            psr_nxt[FLAG_Z] = (A == B);
        else if (op != ALU_ILL && op != ALU_MUL)
            psr_nxt[FLAG_Z] = (res == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            illegal   <= 1'b0;
            C         <= '0;
            psr       <= '0;
        end else begin
            out_valid <= 1'b0;
            illegal   <= 1'b0;
            case (state)
                ST_MUL:  if (mul_done) state <= ST_DONE;
                default: state <= mul_start ? ST_MUL : ST_IDLE;
            endcase
            if (mul_done) begin
                out_valid   <= 1'b1;
                C           <= mul_prod[WIDTH-1:0];
                psr[FLAG_Z] <= (mul_prod[WIDTH-1:0] == '0);
                psr[FLAG_F] <= mul_ovf;
            end else if (fire && !mul_start) begin
                out_valid <= 1'b1;
                illegal   <= (op == ALU_ILL);
                C         <= res;
                psr       <= psr_nxt;
            end
        end
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the datapath width in bits; legal values are 8 to 64.
REQ-002 Parameter MUL_EN, default 1, SHALL enable the multi-cycle MUL opcode when 1; when 0, MUL decodes as illegal.
REQ-003 Port clk  input  1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1: reset is synchronous and active-high.
REQ-005 Port in_valid  input  1: the A/B/Opcode triple is valid this cycle.
REQ-006 Port in_ready  output  1: the block accepts a triple this cycle.
REQ-007 Port A  input  WIDTH: first operand, or destination register value.
REQ-008 Port B  input  WIDTH: second operand, or immediate already sign-extended/zero-extended upstream.
REQ-009 Port Opcode  input  8: operation select.
REQ-010 Port out_valid  output  1: C and Flags are valid; the strobe is one cycle wide.
REQ-011 Port C  output  WIDTH: result.
REQ-012 Port Flags  output  5: {Z,C,F,L,N} = bits [4:0] in the order Z=4, C=3, F=2, L=1, N=0, giving the architectural PSR view.
REQ-013 Port illegal  output  1: pulses with out_valid when the opcode is not decoded.

Function
REQ-014 A transfer SHALL occur when in_valid && in_ready are both high.
- in_ready=1 in IDLE.
- in_ready=0 while MUL is busy.
REQ-015 Single-cycle ops SHALL present the registered C/Flags with out_valid exactly 1 cycle after transfer; back-to-back transfers SHALL sustain 1 result per cycle.
REQ-016 Decode SHALL be as follows; register form has upper nibble 0000, and the immediate form shares its upper nibble with the listed low nibble.
- ADD 05/5x; ADDU 06/6x; ADDC 07/7x; ADDCU 04/4x.
- SUB 09/9x; CMP 0B/Bx.
- AND 01/1x; OR 02/2x; XOR 03/3x; MOV 0D/Dx.
- LSH 84 (B signed: positive = left, negative = right logical, |B| >= WIDTH gives 0).
- MUL 0E.
REQ-017 The carry-in for ADDC, ADDCI, ADDCU and ADDCUI SHALL be the internally held PSR C bit; there is no carry input port.
REQ-018 Signed add/sub (ADD, ADDC, SUB and their immediates) SHALL update F = signed overflow, C = unsigned carry/borrow and Z; all other flags SHALL hold.
REQ-019 Unsigned add (ADDU, ADDCU and their immediates) SHALL update C and Z only.
REQ-020 CMP SHALL write no result (C output = A) and SHALL update the following, leaving F and C unchanged:
- Z = (A==B).
- L = A<B unsigned.
- N = A<B signed.
REQ-021 Logic ops, MOV and LSH SHALL update Z only.
REQ-022 MUL SHALL update Z and F; F=1 when the 2*WIDTH product does not fit in WIDTH signed bits.
REQ-023 MUL SHALL be a shift-add FSM: IDLE -> MUL (WIDTH cycles) -> DONE -> IDLE.
- Signed operands; C output = low WIDTH bits of the product.
- out_valid SHALL assert WIDTH+1 cycles after transfer.
REQ-024 A single-cycle result in flight when MUL is accepted SHALL still emit in order; results never reorder.
REQ-025 An illegal opcode SHALL emit out_valid=1, illegal=1, C=0, and leave the PSR unchanged.
REQ-026 PSR updates SHALL be visible to the next transfer with no bubble; ADDC followed immediately by ADDC chains carry.
REQ-027 All arithmetic SHALL wrap modulo 2^WIDTH.

Reset
REQ-028 On reset high at a clock edge:
- State -> IDLE.
- in_ready=1.
- out_valid=0, illegal=0.
- C=0, Flags=5'b00000.
- The MUL counter is cleared.
REQ-029 Reset mid-MUL SHALL abort the operation; no out_valid is emitted for the aborted operation.

Structure
REQ-030 Package alu_pkg SHALL hold the opcode constants, the flag bit indices, and the FSM state enum.
REQ-031 The multiplier SHALL be a sub-module alu_mul_seq (start, done, WIDTH-parameterised).

Verification
REQ-032 WIDTH=16, PSR C=0, ADD A=0x7FFF B=0x0001:
- C=0x8000, F=1, C-flag=0, Z=0.
- out_valid exactly 1 cycle after transfer.
REQ-033 ADDU A=0xFFFF B=0x0001 -> C=0x0000, C-flag=1, Z=1; then ADDC A=0x0000 B=0x0000 the next cycle -> C=0x0001, Z=0.
REQ-034 CMP A=0xFFFF B=0x0001 -> Z=0, L=0, N=1; C output=0xFFFF; F and C unchanged.
REQ-035 MUL A=-3 B=7, plus a back-to-back ADD offered during busy:
- C=0xFFEB, F=0, out_valid at transfer+17.
- in_ready=0 for cycles 1-16.
- The ADD is accepted afterwards and its result emits after the MUL result.
REQ-036 Reset asserted at MUL cycle 5:
- No out_valid.
- Flags=0 and in_ready=1 on the next cycle.
REQ-037 Opcode 0xFF -> illegal=1, C=0, PSR unchanged; repeat the suite at WIDTH=32 with scaled boundary values.
